// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush sequencer.
// The master side supplies stage status; the slave side returns hold/flush controls.
interface pipe_hazard_ctrl_if;
  logic       im_wait;
  logic       dm_wait;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] exe_rd;
  logic       exe_mem_read;
  logic       exe_branch_taken;
  logic       pc_hold;
  logic       if_id_hold;
  logic       if_id_flush;
  logic       id_exe_hold;
  logic       id_exe_flush;
  logic       waiting;

  modport master (
    output im_wait, dm_wait, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           exe_rd, exe_mem_read, exe_branch_taken,
    input  pc_hold, if_id_hold, if_id_flush, id_exe_hold, id_exe_flush, waiting
  );

  modport slave (
    input  im_wait, dm_wait, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           exe_rd, exe_mem_read, exe_branch_taken,
    output pc_hold, if_id_hold, if_id_flush, id_exe_hold, id_exe_flush, waiting
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait freeze beats branch flush,
// which beats the load-use bubble. Also keeps a saturating stall counter and timeout flag.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_hazard_ctrl_if.slave    hz,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic                 timeout_err
);

  localparam int unsigned FRZ_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {StRun, StFreeze} state_e;

  state_e             state_q, state_d;
  logic               flush_pending_q, flush_pending_d;
  logic [FRZ_W-1:0]   frz_cnt_q, frz_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               timeout_q, timeout_d;

  logic freeze, load_use, br;

  assign freeze   = hz.im_wait | hz.dm_wait;
  assign load_use = hz.exe_mem_read && (hz.exe_rd != 5'd0) &&
                    ((hz.id_use_rs1 && (hz.id_rs1 == hz.exe_rd)) ||
                     (hz.id_use_rs2 && (hz.id_rs2 == hz.exe_rd)));
  assign br       = hz.exe_branch_taken | flush_pending_q;

  // Controls are forced low while reset is asserted, not just after the next edge.
  always_comb begin
    hz.pc_hold      = 1'b0;
    hz.if_id_hold   = 1'b0;
    hz.if_id_flush  = 1'b0;
    hz.id_exe_hold  = 1'b0;
    hz.id_exe_flush = 1'b0;
    hz.waiting      = 1'b0;
    if (rst) begin
      if (freeze) begin
        hz.pc_hold     = 1'b1;
        hz.if_id_hold  = 1'b1;
        hz.id_exe_hold = 1'b1;
        hz.waiting     = 1'b1;
      end else if (br) begin
        hz.if_id_flush  = 1'b1;
        hz.id_exe_flush = 1'b1;
      end else if (load_use) begin
        hz.pc_hold      = 1'b1;
        hz.if_id_hold   = 1'b1;
        hz.id_exe_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (freeze)  state_d = StFreeze;
      StFreeze: if (!freeze) state_d = StRun;
      default:  state_d = StRun;
    endcase

    // A branch resolved under a freeze is remembered and flushed on the release cycle.
    flush_pending_d = freeze ? (flush_pending_q | hz.exe_branch_taken) : 1'b0;

    frz_cnt_d = '0;
    if (TIMEOUT != 0 && state_d == StFreeze) begin
      frz_cnt_d = (frz_cnt_q == FRZ_W'(TIMEOUT)) ? frz_cnt_q : frz_cnt_q + FRZ_W'(1);
    end
    timeout_d = timeout_q | ((TIMEOUT != 0) && (frz_cnt_d == FRZ_W'(TIMEOUT)));

    stall_cnt_d = stall_cnt_q;
    if ((freeze || (load_use && !br)) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StRun;
      flush_pending_q <= 1'b0;
      frz_cnt_q       <= '0;
      stall_cnt_q     <= '0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_pending_q <= flush_pending_d;
      frz_cnt_q       <= frz_cnt_d;
      stall_cnt_q     <= stall_cnt_d;
      timeout_q       <= timeout_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default-sized instance plus a small one
// (CNT_W=3, TIMEOUT=4) driven with identical stimulus.
module tb_pipe_hazard_ctrl;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] FRZ  = 6'b110101; // pc, if_id, id_exe holds + waiting
  localparam logic [5:0] FLS  = 6'b001010; // both flushes
  localparam logic [5:0] LU   = 6'b110010; // pc/if_id hold + id_exe bubble

  logic        clk;
  logic        rst;
  logic [15:0] cnt_a;
  logic [2:0]  cnt_b;
  logic        tmo_a, tmo_b;
  logic [5:0]  ctrl_a, ctrl_b;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string      tag;
    logic [5:0] ctrl;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];

  pipe_hazard_ctrl_if hz_a ();
  pipe_hazard_ctrl_if hz_b ();

  pipe_hazard_ctrl #(.CNT_W(16), .TIMEOUT(1023)) dut_a (
    .clk(clk), .rst(rst), .hz(hz_a.slave), .stall_cnt(cnt_a), .timeout_err(tmo_a)
  );
  pipe_hazard_ctrl #(.CNT_W(3), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .hz(hz_b.slave), .stall_cnt(cnt_b), .timeout_err(tmo_b)
  );

  assign ctrl_a = {hz_a.pc_hold, hz_a.if_id_hold, hz_a.if_id_flush,
                   hz_a.id_exe_hold, hz_a.id_exe_flush, hz_a.waiting};
  assign ctrl_b = {hz_b.pc_hold, hz_b.if_id_hold, hz_b.if_id_flush,
                   hz_b.id_exe_hold, hz_b.id_exe_flush, hz_b.waiting};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic drive(input logic im, input logic dm, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic mr, input logic bt);
    hz_a.im_wait = im;   hz_b.im_wait = im;
    hz_a.dm_wait = dm;   hz_b.dm_wait = dm;
    hz_a.id_rs1 = rs1;   hz_b.id_rs1 = rs1;
    hz_a.id_rs2 = rs2;   hz_b.id_rs2 = rs2;
    hz_a.id_use_rs1 = u1; hz_b.id_use_rs1 = u1;
    hz_a.id_use_rs2 = u2; hz_b.id_use_rs2 = u2;
    hz_a.exe_rd = rd;    hz_b.exe_rd = rd;
    hz_a.exe_mem_read = mr; hz_b.exe_mem_read = mr;
    hz_a.exe_branch_taken = bt; hz_b.exe_branch_taken = bt;
  endtask

  // One cycle: drive, queue expectation, compare controls mid-cycle and counter after the edge.
  task automatic step(input string tag, input logic im, input logic dm, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic u1, input logic u2,
                      input logic [4:0] rd, input logic mr, input logic bt,
                      input logic [5:0] ectrl, input logic [15:0] ecnt);
    exp_t e;
    @(negedge clk);
    drive(im, dm, rs1, rs2, u1, u2, rd, mr, bt);
    sb.push_back('{tag: tag, ctrl: ectrl, cnt: ecnt});
    #1;
    e = sb.pop_front();
    chk({e.tag, "_ctrl_a"}, 32'(ctrl_a), 32'(e.ctrl));
    chk({e.tag, "_ctrl_b"}, 32'(ctrl_b), 32'(e.ctrl));
    @(posedge clk);
    #1;
    chk({e.tag, "_cnt_a"}, 32'(cnt_a), 32'(e.cnt));
  endtask

  task automatic idle(input string tag, input logic [15:0] ecnt);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, ecnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("rst_ctrl_a", 32'(ctrl_a), 32'(NONE));
    chk("rst_cnt_a", 32'(cnt_a), 32'd0);
    chk("rst_tmo_b", 32'(tmo_b), 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    idle("idle", 0);
    step("lu_rs1", 0, 0, 5, 0, 1, 0, 5, 1, 0, LU, 1);
    step("lu_rd0", 0, 0, 0, 0, 1, 0, 0, 1, 0, NONE, 1);
    step("lu_rs2", 0, 0, 3, 7, 0, 1, 7, 1, 0, LU, 2);
    step("lu_nouse", 0, 0, 7, 0, 0, 0, 7, 1, 0, NONE, 2);
    step("lu_noload", 0, 0, 5, 0, 1, 0, 5, 0, 0, NONE, 2);

    step("dm0", 0, 1, 0, 0, 0, 0, 0, 0, 0, FRZ, 3);
    step("dm1", 0, 1, 0, 0, 0, 0, 0, 0, 0, FRZ, 4);
    step("dm2", 0, 1, 0, 0, 0, 0, 0, 0, 0, FRZ, 5);
    idle("dm_rel", 5);

    step("bf0", 0, 1, 0, 0, 0, 0, 0, 0, 0, FRZ, 6);
    step("bf1", 0, 1, 0, 0, 0, 0, 0, 0, 1, FRZ, 7);
    step("bf2", 0, 1, 0, 0, 0, 0, 0, 0, 0, FRZ, 8);
    step("bf_rel", 0, 0, 0, 0, 0, 0, 0, 0, 0, FLS, 8);
    idle("bf_once", 8);

    step("br_lu", 0, 0, 5, 0, 1, 0, 5, 1, 1, FLS, 8);
    idle("br_lu_after", 8);
    step("im_dm", 1, 1, 0, 0, 0, 0, 0, 0, 0, FRZ, 9);
    step("frz_lu", 0, 1, 5, 0, 1, 0, 5, 1, 0, FRZ, 10);
    step("lu_rel", 0, 0, 5, 0, 1, 0, 5, 1, 0, LU, 11);
    step("br", 0, 0, 0, 0, 0, 0, 0, 0, 1, FLS, 11);
    idle("br_after", 11);
    chk("tmo_a_idle", 32'(tmo_a), 32'd0);

    // Reset in the middle of a freeze with a pending branch drops the pending flush.
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_ctrl_a", 32'(ctrl_a), 32'(NONE));
    chk("midrst_cnt_a", 32'(cnt_a), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle("midrst_nopend", 0);

    // Timeout on the small instance: err follows the fourth consecutive freeze cycle.
    for (int i = 0; i < 6; i++) begin
      step($sformatf("im%0d", i), 1, 0, 0, 0, 0, 0, 0, 0, 0, FRZ, 16'(i + 1));
      chk($sformatf("tmo_b_im%0d", i), 32'(tmo_b), (i >= 3) ? 32'd1 : 32'd0);
    end
    idle("im_rel", 6);
    chk("tmo_b_sticky", 32'(tmo_b), 32'd1);
    chk("tmo_a_none", 32'(tmo_a), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("sat%0d", i), 0, 1, 0, 0, 0, 0, 0, 0, 0, FRZ, 16'(i + 7));
    end
    chk("sat_cnt_b", 32'(cnt_b), 32'd7);
    idle("sat_rel", 10);
    chk("sat_hold_b", 32'(cnt_b), 32'd7);

    do_reset();
    #1;
    chk("rst2_tmo_b", 32'(tmo_b), 32'd0);
    chk("rst2_cnt_b", 32'(cnt_b), 32'd0);
    idle("rst2_idle", 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
